datapath: RTL and testbench



---
 rtl/datapath_if.sv | 29 ++
 rtl/datapath.sv | 87 ++++++++
 tb/tb_datapath.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/datapath_if.sv
// Control and memory-side signal bundle for the single-cycle datapath.
// The controller/memory side holds the master view; the datapath holds the slave view.
interface datapath_if;
  logic        memtoreg;
  logic        pcsrc;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        jump;
  logic [2:0]  alucontrol;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol,
    output instr, readdata,
    input  zero, pc, aluout, writedata
  );

  modport slave (
    input  memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol,
    input  instr, readdata,
    output zero, pc, aluout, writedata
  );
endinterface

// File: rtl/datapath.sv
// Single-cycle MIPS-subset datapath: PC, 32x32 register file, sign extension,
// ALU and next-PC selection. Decode lives outside; this block executes controls.
module datapath (
  input  logic       clk,
  input  logic       reset,
  datapath_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [31:0] rd1_s, rd2_s, signimm_s, srcb_s, aluout_s, diff_s;
  logic [31:0] result_s, pcplus4_s, pcbranch_s, pcjump_s;
  logic [4:0]  writereg_s;
  logic        slt_s;
  logic [5:0]  opcode_unused_s;

  // Operand fetch and sign extension; entry 0 of the file is never written, so it reads 0
  always_comb begin
    rd1_s           = rf_q[bus.instr[25:21]];
    rd2_s           = rf_q[bus.instr[20:16]];
    signimm_s       = {{16{bus.instr[15]}}, bus.instr[15:0]};
    srcb_s          = bus.alusrc ? signimm_s : rd2_s;
    opcode_unused_s = bus.instr[31:26];
  end

  // ALU; slt uses the sign of A-B corrected for signed overflow
  always_comb begin
    diff_s = rd1_s - srcb_s;
    slt_s  = diff_s[31] ^ ((rd1_s[31] ^ srcb_s[31]) & (rd1_s[31] ^ diff_s[31]));
    case (bus.alucontrol)
      3'b010:  aluout_s = rd1_s + srcb_s;
      3'b110:  aluout_s = diff_s;
      3'b000:  aluout_s = rd1_s & srcb_s;
      3'b001:  aluout_s = rd1_s | srcb_s;
      3'b111:  aluout_s = {31'd0, slt_s};
      3'b100:  aluout_s = rd1_s & ~srcb_s;
      3'b101:  aluout_s = rd1_s | ~srcb_s;
      3'b011:  aluout_s = 32'd0;
      default: aluout_s = 32'd0;
    endcase
  end

  // Write-back selection and next register-file contents
  always_comb begin
    writereg_s = bus.regdst ? bus.instr[15:11] : bus.instr[20:16];
    result_s   = bus.memtoreg ? bus.readdata : aluout_s;
    rf_d[0]    = 32'd0;
    for (int i = 1; i < 32; i++) begin
      rf_d[i] = (bus.regwrite && (writereg_s == 5'(i))) ? result_s : rf_q[i];
    end
  end

  // Next-PC selection; jump has priority over branch
  always_comb begin
    pcplus4_s  = pc_q + 32'd4;
    pcbranch_s = pcplus4_s + {signimm_s[29:0], 2'b00};
    pcjump_s   = {pcplus4_s[31:28], bus.instr[25:0], 2'b00};
    if (bus.jump) begin
      pc_d = pcjump_s;
    end else if (bus.pcsrc) begin
      pc_d = pcbranch_s;
    end else begin
      pc_d = pcplus4_s;
    end
  end

  // Architectural state: PC and register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.aluout    = aluout_s;
  assign bus.writedata = rd2_s;
  assign bus.zero      = (aluout_s == 32'd0);

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized cycles
// compared against an architectural reference model (register array + PC).
module tb_datapath;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_if bus();
  datapath u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] e_alu, e_wd, e_pcnext;
  logic        e_zero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] ac, input logic as, input logic rd, input logic rw,
                       input logic mt, input logic ps, input logic j,
                       input logic [31:0] ins, input logic [31:0] rdv);
    bus.alucontrol = ac;
    bus.alusrc     = as;
    bus.regdst     = rd;
    bus.regwrite   = rw;
    bus.memtoreg   = mt;
    bus.pcsrc      = ps;
    bus.jump       = j;
    bus.instr      = ins;
    bus.readdata   = rdv;
  endtask

  // Architectural reference: what one instruction computes from the ISA rules
  task automatic model_eval;
    logic [31:0] a, b, rt_val, imm, p4;
    a      = m_regs[bus.instr[25:21]];
    rt_val = m_regs[bus.instr[20:16]];
    imm    = 32'($signed(bus.instr[15:0]));
    b      = bus.alusrc ? imm : rt_val;
    case (bus.alucontrol)
      3'd2:    e_alu = a + b;
      3'd6:    e_alu = a - b;
      3'd0:    e_alu = a & b;
      3'd1:    e_alu = a | b;
      3'd7:    e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    e_alu = a & ~b;
      3'd5:    e_alu = a | ~b;
      default: e_alu = 32'd0;
    endcase
    e_zero = (e_alu == 32'd0);
    e_wd   = rt_val;
    p4     = m_pc + 32'd4;
    if (bus.jump)       e_pcnext = {p4[31:28], bus.instr[25:0], 2'b00};
    else if (bus.pcsrc) e_pcnext = p4 + imm * 32'd4;
    else                e_pcnext = p4;
  endtask

  task automatic check_outs(input string tag);
    model_eval();
    chk({tag, "_aluout"}, bus.aluout, e_alu);
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e_zero});
    chk({tag, "_writedata"}, bus.writedata, e_wd);
    chk({tag, "_pc"}, bus.pc, m_pc);
  endtask

  task automatic tick;
    logic [4:0]  wr;
    logic [31:0] res;
    logic        we;
    model_eval();
    wr  = bus.regdst ? bus.instr[15:11] : bus.instr[20:16];
    res = bus.memtoreg ? bus.readdata : e_alu;
    we  = bus.regwrite;
    @(posedge clk);
    if (we && wr != 5'd0) m_regs[wr] = res;
    m_pc = e_pcnext;
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = 32'd0;
  endtask

  initial begin
    reset = 1'b0;
    drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();
    #3;
    chk("reset_pc", bus.pc, 32'd0);
    chk("reset_aluout", bus.aluout, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // addi $1,$0,5 and addi $2,$0,7
    drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20010005, 32'd0);
    #2; check_outs("addi1"); chk("addi1_five", bus.aluout, 32'd5); tick();
    drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20020007, 32'd0);
    #2; check_outs("addi2"); tick();

    // R-type rs=1 rt=2 rd=3, no write
    drive(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'd0);
    #2; check_outs("radd"); chk("radd_12", bus.aluout, 32'd12);
    drive(3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'd0);
    #2; chk("rsub", bus.aluout, 32'hFFFFFFFE);
    drive(3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'd0);
    #2; chk("rslt", bus.aluout, 32'd1);

    // write to $0 must be ignored
    drive(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00220020, 32'd0);
    #2; check_outs("wr0"); tick();
    drive(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000020, 32'd0);
    #2; chk("r0_zero", bus.aluout, 32'd0); chk("r0_wd", bus.writedata, 32'd0);

    // slt with $1 = -1, $2 = 1
    drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2001FFFF, 32'd0); #2; tick();
    drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20020001, 32'd0); #2; tick();
    drive(3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00221820, 32'd0);
    #2; check_outs("slt_neg"); chk("slt_neg_1", bus.aluout, 32'd1);

    // branch backwards from pc 8 with rs == rt
    drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h08000002, 32'd0); #2; tick();
    chk("jmp_to_8", bus.pc, 32'd8);
    drive(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1021FFFE, 32'd0);
    #2; check_outs("beq"); chk("beq_zero", {31'd0, bus.zero}, 32'd1); tick();
    chk("beq_pc", bus.pc, 32'd4);

    // jump overrides branch
    drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h08000004, 32'd0); #2; tick();
    chk("jmp_to_10", bus.pc, 32'h10);
    drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h08000040, 32'd0); #2; tick();
    chk("jmp_pri", bus.pc, 32'h100);

    // lw $4,0($0) then sw $4,16($1)
    drive(3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8C040000, 32'hDEADBEEF); #2; tick();
    drive(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAC240010, 32'd0);
    #2; check_outs("sw"); chk("sw_wd", bus.writedata, 32'hDEADBEEF); chk("sw_addr", bus.aluout, 32'h0000000F);

    // randomized cycles
    for (int i = 0; i < 300; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom, $urandom);
      #2; check_outs("rand"); tick();
    end

    // asynchronous reset mid-cycle with a write pending
    drive(3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, $urandom, 32'h12345678);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_pc", bus.pc, 32'd0);
    chk("midrst_alu", bus.aluout, 32'd0);
    chk("midrst_wd", bus.writedata, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check_outs("inrst");
    @(negedge clk);
    reset = 1'b1;
    drive(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom & 32'h03FFFFFF, 32'd0);
    #2; check_outs("postrst"); tick();
    chk("postrst_pc4", bus.pc, 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'd0);
      #2; check_outs("rdclr"); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
